// File: rtl/wb_dma_req_sched.sv
// Round-robin DMA handshake scheduler: grants one peripheral channel at a time,
// bounds each grant by burst length, last-marker, restart or no-ack timeout.
module wb_dma_req_sched #(
   parameter int N_CH    = 8,
   parameter int BURST_W = 4,
   parameter int TO_W    = 8
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [N_CH-1:0]     chan_en,
   input  logic [BURST_W-1:0]  burst_len,
   input  logic [TO_W-1:0]     timeout,
   input  logic [N_CH-1:0]     periph_req,
   input  logic [N_CH-1:0]     periph_last,
   output logic [N_CH-1:0]     periph_ack,
   input  logic [N_CH-1:0]     chan_restart,
   output logic [N_CH-1:0]     dma_req_o,
   output logic [N_CH-1:0]     dma_nd_o,
   output logic [N_CH-1:0]     dma_rest_o,
   input  logic [N_CH-1:0]     dma_ack_i,
   output logic [N_CH-1:0]     grant_o,
   output logic                busy,
   output logic [N_CH-1:0]     to_err,
   input  logic [N_CH-1:0]     err_clr
);

   localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

   state_t             state_q, state_d;
   logic [N_CH-1:0]    grant_q, grant_d;
   logic [PW-1:0]      gidx_q, gidx_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [BURST_W-1:0] beat_q, beat_d;
   logic [TO_W-1:0]    to_q, to_d;
   logic [N_CH-1:0]    to_err_q, to_err_d;
   logic [N_CH-1:0]    pack_q, pack_d;
   logic [N_CH-1:0]    nd_q, nd_d;
   logic [N_CH-1:0]    rest_q, rest_d;

   logic [N_CH-1:0]    elig;
   logic [N_CH-1:0]    err_set;
   logic               pick_vld;
   logic [PW-1:0]      pick_idx;
   logic [BURST_W:0]   beat_inc;
   logic [TO_W:0]      to_inc;
   logic               g_ack;
   logic               g_abort;

   // Rotating priority: first eligible channel at or above ptr, wrapping.
   always_comb begin
      int unsigned idx;
      elig     = periph_req & chan_en & ~to_err_q;
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= N_CH) idx = idx - N_CH;
         if (!pick_vld && elig[idx]) begin
            pick_vld = 1'b1;
            pick_idx = PW'(idx);
         end
      end
   end

   assign beat_inc = {1'b0, beat_q} + {{BURST_W{1'b0}}, 1'b1};
   assign to_inc   = {1'b0, to_q} + {{TO_W{1'b0}}, 1'b1};
   assign g_ack    = dma_ack_i[gidx_q];
   assign g_abort  = chan_restart[gidx_q] | ~periph_req[gidx_q] | ~chan_en[gidx_q];

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      beat_d  = beat_q;
      to_d    = to_q;
      pack_d  = '0;
      nd_d    = '0;
      rest_d  = chan_restart;
      err_set = '0;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               gidx_d            = pick_idx;
               beat_d            = '0;
               to_d              = '0;
               state_d           = REQ;
            end
         end
         REQ: begin
            if (g_ack) begin
               pack_d[gidx_q] = 1'b1;
               beat_d         = (&beat_q) ? beat_q : beat_inc[BURST_W-1:0];
               to_d           = '0;
               if (periph_last[gidx_q]) begin
                  nd_d[gidx_q] = 1'b1;
                  state_d      = GAP;
               end else if ((burst_len != '0) && (beat_inc == {1'b0, burst_len})) begin
                  state_d = GAP;
               end else if (chan_restart[gidx_q]) begin
                  state_d = GAP;
               end
            end else if (g_abort) begin
               state_d = GAP;
            end else begin
               to_d = (&to_q) ? to_q : to_inc[TO_W-1:0];
               if ((timeout != '0) && (to_inc == {1'b0, timeout})) begin
                  err_set[gidx_q] = 1'b1;
                  state_d         = GAP;
               end
            end
         end
         GAP: begin
            ptr_d   = (gidx_q == PW'(N_CH - 1)) ? '0 : gidx_q + 1'b1;
            grant_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A timeout set wins over a clear landing in the same cycle.
      to_err_d = (to_err_q & ~err_clr) | err_set;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         gidx_q   <= '0;
         ptr_q    <= '0;
         beat_q   <= '0;
         to_q     <= '0;
         to_err_q <= '0;
         pack_q   <= '0;
         nd_q     <= '0;
         rest_q   <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         gidx_q   <= gidx_d;
         ptr_q    <= ptr_d;
         beat_q   <= beat_d;
         to_q     <= to_d;
         to_err_q <= to_err_d;
         pack_q   <= pack_d;
         nd_q     <= nd_d;
         rest_q   <= rest_d;
      end
   end

   assign dma_req_o  = (state_q == REQ) ? grant_q : '0;
   assign grant_o    = grant_q;
   assign busy       = (state_q != IDLE);
   assign periph_ack = pack_q;
   assign dma_nd_o   = nd_q;
   assign dma_rest_o = rest_q;
   assign to_err     = to_err_q;

endmodule

// File: tb/tb_wb_dma_req_sched.sv
// Cycle-exact directed bench for wb_dma_req_sched: vectors carry per-cycle
// inputs and the outputs expected after the following clock edge.
module tb_wb_dma_req_sched;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] chan_en, periph_req, periph_last, periph_ack, chan_restart;
   logic [7:0] dma_req_o, dma_nd_o, dma_rest_o, dma_ack_i, grant_o, to_err, err_clr;
   logic [3:0] burst_len;
   logic [7:0] timeout;
   logic       busy;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      string      name;
      logic [7:0] req, dack, last, rst, clr;
      logic [7:0] e_dreq, e_grant, e_pack, e_nd, e_rest, e_err;
      logic       e_busy;
   } vec_t;

   vec_t exp_q[$];
   vec_t tbl[$];

   always #5 clk = ~clk;

   wb_dma_req_sched #(.N_CH(8), .BURST_W(4), .TO_W(8)) dut (
      .clk(clk), .rstn(rstn), .chan_en(chan_en), .burst_len(burst_len),
      .timeout(timeout), .periph_req(periph_req), .periph_last(periph_last),
      .periph_ack(periph_ack), .chan_restart(chan_restart), .dma_req_o(dma_req_o),
      .dma_nd_o(dma_nd_o), .dma_rest_o(dma_rest_o), .dma_ack_i(dma_ack_i),
      .grant_o(grant_o), .busy(busy), .to_err(to_err), .err_clr(err_clr)
   );

   function automatic vec_t V(input string n,
                              input logic [7:0] req, dack, last, rst, clr,
                              input logic [7:0] edreq, egrant, epack, end_, erest, eerr,
                              input logic ebusy);
      vec_t v;
      v.name = n; v.req = req; v.dack = dack; v.last = last; v.rst = rst; v.clr = clr;
      v.e_dreq = edreq; v.e_grant = egrant; v.e_pack = epack; v.e_nd = end_;
      v.e_rest = erest; v.e_err = eerr; v.e_busy = ebusy;
      return v;
   endfunction

   task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", n, act, exp);
      end
   endtask

   task automatic compare(input vec_t e);
      chk({e.name, ".dma_req"}, dma_req_o, e.e_dreq);
      chk({e.name, ".grant"}, grant_o, e.e_grant);
      chk({e.name, ".periph_ack"}, periph_ack, e.e_pack);
      chk({e.name, ".dma_nd"}, dma_nd_o, e.e_nd);
      chk({e.name, ".dma_rest"}, dma_rest_o, e.e_rest);
      chk({e.name, ".to_err"}, to_err, e.e_err);
      chk({e.name, ".busy"}, {7'd0, busy}, {7'd0, e.e_busy});
   endtask

   // Drive one cycle of stimulus, then score the outputs after the next edge.
   task automatic run(input vec_t v);
      periph_req   = v.req;
      dma_ack_i    = v.dack;
      periph_last  = v.last;
      chan_restart = v.rst;
      err_clr      = v.clr;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      compare(exp_q.pop_front());
   endtask

   task automatic check_now(input vec_t v);
      exp_q.push_back(v);
      compare(exp_q.pop_front());
   endtask

   task automatic run_tbl();
      foreach (tbl[i]) run(tbl[i]);
      tbl.delete();
   endtask

   task automatic do_reset();
      periph_req = '0; dma_ack_i = '0; periph_last = '0; chan_restart = '0; err_clr = '0;
      rstn = 1'b0;
      #1;
      check_now(V("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      chan_en = 8'hFF; burst_len = 4'd0; timeout = 8'd0;
      periph_req = '0; dma_ack_i = '0; periph_last = '0; chan_restart = '0; err_clr = '0;
      repeat (2) @(posedge clk);
      #1;
      check_now(V("por", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rstn = 1'b1;

      // Round-robin with single-beat bursts; 8'h50 includes a stray ch6 ack.
      chan_en = 8'hFF; burst_len = 4'd1; timeout = 8'd0;
      tbl.push_back(V("rr0",  8'h13, 8'h00, 0, 0, 0, 8'h01, 8'h01, 8'h00, 0, 0, 0, 1));
      tbl.push_back(V("rr1",  8'h13, 8'h01, 0, 0, 0, 8'h00, 8'h01, 8'h01, 0, 0, 0, 1));
      tbl.push_back(V("rr2",  8'h13, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
      tbl.push_back(V("rr3",  8'h13, 8'h00, 0, 0, 0, 8'h02, 8'h02, 8'h00, 0, 0, 0, 1));
      tbl.push_back(V("rr4",  8'h13, 8'h02, 0, 0, 0, 8'h00, 8'h02, 8'h02, 0, 0, 0, 1));
      tbl.push_back(V("rr5",  8'h13, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
      tbl.push_back(V("rr6",  8'h13, 8'h00, 0, 0, 0, 8'h10, 8'h10, 8'h00, 0, 0, 0, 1));
      tbl.push_back(V("rr7",  8'h13, 8'h50, 0, 0, 0, 8'h00, 8'h10, 8'h10, 0, 0, 0, 1));
      tbl.push_back(V("rr8",  8'h13, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
      tbl.push_back(V("rr9",  8'h13, 8'h00, 0, 0, 0, 8'h01, 8'h01, 8'h00, 0, 0, 0, 1));
      tbl.push_back(V("rr10", 8'h13, 8'h01, 0, 0, 0, 8'h00, 8'h01, 8'h01, 0, 0, 0, 1));
      tbl.push_back(V("rr11", 8'h13, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
      tbl.push_back(V("rr12", 8'h13, 8'h00, 0, 0, 0, 8'h02, 8'h02, 8'h00, 0, 0, 0, 1));
      run_tbl();

      // Single channel, burst of 4, ack every third cycle.
      do_reset();
      chan_en = 8'h01; burst_len = 4'd4; timeout = 8'd0;
      tbl.push_back(V("s0", 8'h01, 0, 0, 0, 0, 8'h01, 8'h01, 0, 0, 0, 0, 1));
      for (int k = 1; k <= 12; k++) begin
         logic [7:0] a;
         a = (k % 3 == 0) ? 8'h01 : 8'h00;
         tbl.push_back(V($sformatf("s%0d", k), 8'h01, a, 0, 0, 0,
                         (k == 12) ? 8'h00 : 8'h01, 8'h01, a, 0, 0, 0, 1));
      end
      tbl.push_back(V("s13", 8'h01, 8'h01, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
      tbl.push_back(V("s14", 8'h01, 8'h00, 0, 0, 0, 8'h01, 8'h01, 8'h00, 0, 0, 0, 1));
      run_tbl();

      // Unlimited burst ended by periph_last on the third ack.
      do_reset();
      chan_en = 8'hFF; burst_len = 4'd0; timeout = 8'd0;
      tbl.push_back(V("l0", 8'h04, 8'h00, 8'h00, 0, 0, 8'h04, 8'h04, 8'h00, 8'h00, 0, 0, 1));
      tbl.push_back(V("l1", 8'h04, 8'h04, 8'h00, 0, 0, 8'h04, 8'h04, 8'h04, 8'h00, 0, 0, 1));
      tbl.push_back(V("l2", 8'h04, 8'h04, 8'h00, 0, 0, 8'h04, 8'h04, 8'h04, 8'h00, 0, 0, 1));
      tbl.push_back(V("l3", 8'h04, 8'h04, 8'h04, 0, 0, 8'h00, 8'h04, 8'h04, 8'h04, 0, 0, 1));
      tbl.push_back(V("l4", 8'h04, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
      run_tbl();

      // Timeout of 10 cycles, exclusion, clear, then set/clear collision.
      do_reset();
      chan_en = 8'hFF; burst_len = 4'd0; timeout = 8'd10;
      tbl.push_back(V("t0", 8'h20, 0, 0, 0, 0, 8'h20, 8'h20, 0, 0, 0, 8'h00, 1));
      for (int k = 1; k <= 9; k++)
         tbl.push_back(V($sformatf("t%0d", k), 8'h20, 0, 0, 0, 0, 8'h20, 8'h20, 0, 0, 0, 8'h00, 1));
      tbl.push_back(V("t10", 8'h20, 0, 0, 0, 0,     8'h00, 8'h20, 0, 0, 0, 8'h20, 1));
      tbl.push_back(V("t11", 8'h20, 0, 0, 0, 0,     8'h00, 8'h00, 0, 0, 0, 8'h20, 0));
      tbl.push_back(V("t12", 8'h20, 0, 0, 0, 0,     8'h00, 8'h00, 0, 0, 0, 8'h20, 0));
      tbl.push_back(V("t13", 8'h20, 0, 0, 0, 8'h20, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0));
      tbl.push_back(V("t14", 8'h20, 0, 0, 0, 0,     8'h20, 8'h20, 0, 0, 0, 8'h00, 1));
      for (int k = 15; k <= 23; k++)
         tbl.push_back(V($sformatf("t%0d", k), 8'h20, 0, 0, 0, 0, 8'h20, 8'h20, 0, 0, 0, 8'h00, 1));
      tbl.push_back(V("t24", 8'h20, 0, 0, 0, 8'h20, 8'h00, 8'h20, 0, 0, 0, 8'h20, 1));
      tbl.push_back(V("t25", 8'h20, 0, 0, 0, 0,     8'h00, 8'h00, 0, 0, 0, 8'h20, 0));
      run_tbl();

      // Restart abort, restart coinciding with ack, idle restart, stray ack.
      do_reset();
      chan_en = 8'hFF; burst_len = 4'd0; timeout = 8'd0;
      tbl.push_back(V("r0", 8'h08, 8'h00, 0, 8'h00, 0, 8'h08, 8'h08, 8'h00, 0, 8'h00, 0, 1));
      tbl.push_back(V("r1", 8'h08, 8'h00, 0, 8'h08, 0, 8'h00, 8'h08, 8'h00, 0, 8'h08, 0, 1));
      tbl.push_back(V("r2", 8'h08, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0));
      tbl.push_back(V("r3", 8'h08, 8'h00, 0, 8'h00, 0, 8'h08, 8'h08, 8'h00, 0, 8'h00, 0, 1));
      tbl.push_back(V("r4", 8'h08, 8'h08, 0, 8'h08, 0, 8'h00, 8'h08, 8'h08, 0, 8'h08, 0, 1));
      tbl.push_back(V("r5", 8'h08, 8'h00, 0, 8'h40, 0, 8'h00, 8'h00, 8'h00, 0, 8'h40, 0, 0));
      tbl.push_back(V("r6", 8'h08, 8'h00, 0, 8'h00, 0, 8'h08, 8'h08, 8'h00, 0, 8'h00, 0, 1));
      tbl.push_back(V("r7", 8'h08, 8'h40, 0, 8'h00, 0, 8'h08, 8'h08, 8'h00, 0, 8'h00, 0, 1));
      run_tbl();

      // Asynchronous reset during REQ; ptr was 4, so ch3 wins over ch7 only if reset to 0.
      periph_req = 8'h88; dma_ack_i = 8'h08;
      rstn = 1'b0;
      #1;
      check_now(V("mr_async", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      check_now(V("mr_held", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rstn = 1'b1;
      run(V("mr_regrant", 8'h88, 8'h00, 0, 0, 0, 8'h08, 8'h08, 8'h00, 0, 0, 0, 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
